// File: rtl/sa_ifmap_feeder.sv
// Systolic-array ifmap feeder: accepts ifmap vectors, skews them per row,
// and produces the row-enable and column psum-enable strobes in array bit order.
module sa_ifmap_feeder #(
  parameter int unsigned SA_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  input  logic [CNT_WIDTH-1:0]           vec_cnt_i,
  input  logic                           vec_valid_i,
  output logic                           vec_ready_o,
  input  logic [SA_WIDTH*DATA_WIDTH-1:0] vec_data_i,
  output logic [SA_WIDTH*DATA_WIDTH-1:0] ifmap_row_o,
  output logic [SA_WIDTH-1:0]            ifmap_en_o,
  output logic [SA_WIDTH-1:0]            psum_en_o,
  output logic                           busy_o,
  output logic                           done_o
);

  localparam int unsigned DRAIN_W = (SA_WIDTH > 1) ? $clog2(SA_WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [SA_WIDTH-1:0]  en_pipe_q;
  logic                 hs;

  // Ready depends on state only so the buffer never sees a combinational loop
  assign vec_ready_o = (state_q == S_FEED);
  assign hs          = vec_valid_i && vec_ready_o;

  // State, tile counter and drain counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      drain_q     <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      drain_q     <= drain_d;
      busy_o      <= (state_d != S_IDLE);
      done_o      <= (state_d == S_DONE);
    end
  end

  // Next-state logic; DRAIN holds long enough for the last row to empty
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    drain_d     = drain_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (vec_cnt_i != '0) begin
            state_d     = S_FEED;
            remaining_d = vec_cnt_i;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FEED: begin
        if (hs && (remaining_q != '0)) begin
          remaining_d = remaining_q - CNT_WIDTH'(1);
          if (remaining_q == CNT_WIDTH'(1)) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + DRAIN_W'(1);
        if (drain_q == DRAIN_W'(SA_WIDTH - 1)) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Enable delay line: stage k is the row-0 enable delayed k cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_pipe_q <= '0;
    end else begin
      en_pipe_q[0] <= hs;
      for (int k = 1; k < int'(SA_WIDTH); k++) begin
        en_pipe_q[k] <= en_pipe_q[k-1];
      end
    end
  end

  for (genvar r = 0; r < int'(SA_WIDTH); r++) begin : g_row
    logic [DATA_WIDTH-1:0] dly_q [r+1];

    // Per-row data skew; bubbles enter as zero so gating is already applied
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k <= r; k++) begin
          dly_q[k] <= '0;
        end
      end else begin
        dly_q[0] <= hs ? vec_data_i[r*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int k = 1; k <= r; k++) begin
          dly_q[k] <= dly_q[k-1];
        end
      end
    end

    assign ifmap_row_o[r*DATA_WIDTH +: DATA_WIDTH] = dly_q[r];
    assign ifmap_en_o[SA_WIDTH-1-r]                = en_pipe_q[r];
    assign psum_en_o[SA_WIDTH-1-r]                 = en_pipe_q[r];
  end

endmodule

// File: tb/tb_sa_ifmap_feeder.sv
// Self-checking bench for sa_ifmap_feeder: directed scenarios plus random traffic
// compared against a timeline model of accepted vectors.
module tb_sa_ifmap_feeder;

  localparam int unsigned SA = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;
  localparam int unsigned VW = SA * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [CW-1:0] vec_cnt_i;
  logic          vec_valid_i;
  logic          vec_ready_o;
  logic [VW-1:0] vec_data_i;
  logic [VW-1:0] ifmap_row_o;
  logic [SA-1:0] ifmap_en_o;
  logic [SA-1:0] psum_en_o;
  logic          busy_o;
  logic          done_o;

  sa_ifmap_feeder #(.SA_WIDTH(SA), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .vec_cnt_i(vec_cnt_i),
    .vec_valid_i(vec_valid_i), .vec_ready_o(vec_ready_o), .vec_data_i(vec_data_i),
    .ifmap_row_o(ifmap_row_o), .ifmap_en_o(ifmap_en_o), .psum_en_o(psum_en_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: which edge accepted which vector, plus tile bookkeeping
  bit            hs_hist   [int];
  logic [VW-1:0] data_hist [int];
  int            n       = 0;
  bit            active  = 0;
  bit            feeding = 0;
  int            left    = 0;
  int            done_at = -10;
  localparam int UNKNOWN = 32'h3fff_ffff;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  function automatic bit m_idle(input int m);
    return !active || (m > done_at + 1);
  endfunction

  // One clock cycle: drive inputs, step the model at the edge, check outputs after it
  task automatic cyc(input bit st, input logic [CW-1:0] cnt, input bit v, input logic [VW-1:0] d);
    bit            hs;
    logic [SA-1:0] exp_en;
    logic [VW-1:0] exp_row;
    start_i = st; vec_cnt_i = cnt; vec_valid_i = v; vec_data_i = d;
    #1;
    chk("ready", VW'(vec_ready_o), VW'(feeding));
    hs = v && feeding;
    hs_hist[n]   = hs;
    data_hist[n] = d;
    @(posedge clk);
    if (active && m_idle(n)) active = 0;
    if (feeding && hs) begin
      left--;
      if (left == 0) begin
        feeding = 0;
        done_at = n + int'(SA);
      end
    end else if (!active && st) begin
      active = 1;
      if (cnt != 0) begin
        feeding = 1;
        left    = int'(cnt);
        done_at = UNKNOWN;
      end else begin
        done_at = n;
      end
    end
    #1;
    exp_en  = '0;
    exp_row = '0;
    for (int r = 0; r < int'(SA); r++) begin
      int idx;
      idx = n - r;
      if (hs_hist.exists(idx) && hs_hist[idx]) begin
        exp_en[SA-1-r]      = 1'b1;
        exp_row[r*DW +: DW] = data_hist[idx][r*DW +: DW];
      end
    end
    chk("ifmap_en", VW'(ifmap_en_o), VW'(exp_en));
    chk("psum_en",  VW'(psum_en_o),  VW'(exp_en));
    chk("ifmap_row", ifmap_row_o, exp_row);
    chk("busy", VW'(busy_o), VW'(active && (n <= done_at)));
    chk("done", VW'(done_o), VW'(active && (n == done_at)));
    n++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, '0, 0, VW'($urandom));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, VW'(vec_ready_o), '0);
    chk({tag, "_row"},   ifmap_row_o, '0);
    chk({tag, "_en"},    VW'(ifmap_en_o), '0);
    chk({tag, "_psum"},  VW'(psum_en_o), '0);
    chk({tag, "_busy"},  VW'(busy_o), '0);
    chk({tag, "_done"},  VW'(done_o), '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk_all_zero("reset");
    active = 0; feeding = 0; left = 0; done_at = -10;
    hs_hist.delete();
    data_hist.delete();
    @(posedge clk); n++;
    @(posedge clk); n++;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start_i = 0; vec_cnt_i = '0; vec_valid_i = 0; vec_data_i = '0;
    #2;
    do_reset();
    idle(2);

    // 1: three back-to-back vectors with valid held high
    cyc(1, 8'd3, 1, 32'h0403_0201);
    cyc(0, '0, 1, 32'h0403_0201);
    cyc(0, '0, 1, 32'h1413_1211);
    cyc(0, '0, 1, 32'h2423_2221);
    idle(8);

    // 2: one bubble between two vectors
    cyc(1, 8'd2, 0, '0);
    cyc(0, '0, 1, 32'hA4A3_A2A1);
    cyc(0, '0, 0, 32'hDEAD_BEEF);
    cyc(0, '0, 1, 32'hB4B3_B2B1);
    idle(8);

    // 3: empty tile
    cyc(1, 8'd0, 1, 32'h1234_5678);
    idle(4);

    // 4: start pulses during FEED are ignored
    cyc(1, 8'd3, 0, '0);
    cyc(0, '0, 1, 32'h0C0B_0A09);
    cyc(1, 8'd7, 1, 32'h1C1B_1A19);
    cyc(1, 8'd1, 0, 32'h0);
    cyc(0, '0, 1, 32'h2C2B_2A29);
    cyc(0, '0, 1, 32'h3C3B_3A39);
    idle(8);

    // 5: reset during DRAIN of a four-vector tile
    cyc(1, 8'd4, 0, '0);
    for (int i = 0; i < 4; i++) cyc(0, '0, 1, VW'($urandom));
    idle(2);
    do_reset();
    idle(8);

    // 6: back-to-back tiles, second start in the cycle after done
    cyc(1, 8'd2, 0, '0);
    cyc(0, '0, 1, 32'h5555_5555);
    cyc(0, '0, 1, 32'h6666_6666);
    for (int guard = 0; guard < 20 && n < done_at + 2; guard++) idle(1);
    chk("b2b_idle", VW'(m_idle(n)), VW'(1));
    cyc(1, 8'd2, 1, 32'h7777_7777);
    cyc(0, '0, 1, 32'h8888_8888);
    cyc(0, '0, 1, 32'h9999_9999);
    idle(8);

    // Random traffic: random starts, counts, valids and data
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 3) == 0), CW'($urandom_range(0, 6)),
          ($urandom_range(0, 9) < 7), VW'($urandom));
    end
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
